// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, debounce FSM,
// edge pulses and long-press / auto-repeat pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_LO     | debounced low, waiting for a high sample
// ST_LO2HI  | high seen, counting stable highs before accepting
// ST_HI     | debounced high, long-press counter running
// ST_HI2LO  | low seen, counting stable lows before accepting; lcnt frozen
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_CYC    = 1000000,
    parameter int LONG_CYC    = 50000000,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_CYC  = 10000000,
    parameter int CNT_W       = 32
) (
    input  logic            clk50m,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] sw_dbnc,
    output logic [N_CH-1:0] sw_hi,
    output logic [N_CH-1:0] sw_lo,
    output logic [N_CH-1:0] sw_long
);

    localparam logic [1:0] ST_LO    = 2'd0;
    localparam logic [1:0] ST_LO2HI = 2'd1;
    localparam logic [1:0] ST_HI    = 2'd2;
    localparam logic [1:0] ST_HI2LO = 2'd3;

    localparam int LONG_LAST_I = (LONG_CYC > 0) ? LONG_CYC - 1 : 0;
    // A repeat period longer than the first delay falls back to reloading 0.
    localparam int RELOAD_I    = (REPEAT_CYC >= LONG_CYC) ? 0 : LONG_CYC - REPEAT_CYC;

    localparam logic [CNT_W-1:0] DBNC_LAST   = CNT_W'(DBNC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_LAST_I);
    localparam logic [CNT_W-1:0] LONG_HOLD   = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LONG_RELOAD = CNT_W'(RELOAD_I);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q  [N_CH];
    logic [1:0]             state_q [N_CH];
    logic [CNT_W-1:0]       dcnt_q  [N_CH];
    logic [CNT_W-1:0]       lcnt_q  [N_CH];
    logic [N_CH-1:0]        s;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync_out
        assign s[g] = sync_q[g][SYNC_STAGES-1];
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sw_dbnc <= '0;
            sw_hi   <= '0;
            sw_lo   <= '0;
            sw_long <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_LO;
                dcnt_q[i]  <= '0;
                lcnt_q[i]  <= '0;
            end
        end else begin
            sw_hi   <= '0;
            sw_lo   <= '0;
            sw_long <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw[i]};
                case (state_q[i])
                    ST_LO: begin
                        if (s[i]) begin
                            state_q[i] <= ST_LO2HI;
                            dcnt_q[i]  <= '0;
                        end
                    end
                    ST_LO2HI: begin
                        if (!s[i]) begin
                            state_q[i] <= ST_LO;
                        end else if (dcnt_q[i] == DBNC_LAST) begin
                            state_q[i] <= ST_HI;
                            sw_dbnc[i] <= 1'b1;
                            sw_hi[i]   <= 1'b1;
                            lcnt_q[i]  <= '0;
                        end else if (dcnt_q[i] < DBNC_LAST) begin
                            dcnt_q[i] <= dcnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_HI: begin
                        if (!s[i]) begin
                            state_q[i] <= ST_HI2LO;
                            dcnt_q[i]  <= '0;
                        end else if (LONG_CYC != 0) begin
                            // Without repeat, parking at LONG_CYC blocks further pulses.
                            if (lcnt_q[i] == LONG_LAST) begin
                                sw_long[i] <= 1'b1;
                                lcnt_q[i]  <= (REPEAT_EN != 0) ? LONG_RELOAD : LONG_HOLD;
                            end else if (lcnt_q[i] < LONG_LAST) begin
                                lcnt_q[i] <= lcnt_q[i] + CNT_ONE;
                            end
                        end
                    end
                    ST_HI2LO: begin
                        if (s[i]) begin
                            state_q[i] <= ST_HI;
                        end else if (dcnt_q[i] == DBNC_LAST) begin
                            state_q[i] <= ST_LO;
                            sw_dbnc[i] <= 1'b0;
                            sw_lo[i]   <= 1'b1;
                            lcnt_q[i]  <= '0;
                        end else if (dcnt_q[i] < DBNC_LAST) begin
                            dcnt_q[i] <= dcnt_q[i] + CNT_ONE;
                        end
                    end
                    default: state_q[i] <= ST_LO;
                endcase
            end
        end
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor of the single-switch debouncer.
- Each of N_CH raw switch/button inputs is synchronised and filtered by its own counter-based state machine.
- Per channel it outputs the debounced level, single-cycle rise/fall pulses, and a long-press pulse with optional auto-repeat.
- Sits between board pins and user-interface logic in the clk50m domain.

Parameters:
N_CH, 4, number of independent channels (1..32)
SYNC_STAGES, 2, synchroniser flop depth per channel (2..4)
DBNC_CYC, 1000000, consecutive stable synchronised cycles needed to accept a level change (20 ms at 50 MHz; >=1)
LONG_CYC, 50000000, cycles of debounced-high before the first sw_long pulse; 0 disables long-press
REPEAT_EN, 0, 1 = keep pulsing sw_long every REPEAT_CYC while held high
REPEAT_CYC, 10000000, auto-repeat period in cycles (>=1)
CNT_W, 32, counter width; must hold max(DBNC_CYC, LONG_CYC, REPEAT_CYC)

Ports:
clk50m  input  1  system clock, 50 MHz, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  N_CH  raw, asynchronous, bouncing inputs (1 = pressed)
sw_dbnc  output  N_CH  debounced level per channel
sw_hi  output  N_CH  one-cycle pulse when sw_dbnc goes 0->1
sw_lo  output  N_CH  one-cycle pulse when sw_dbnc goes 1->0
sw_long  output  N_CH  one-cycle long-press / auto-repeat pulse

Behaviour:
- Reset (rst_n=0, async): all synchroniser flops, counters, FSMs and outputs go to 0; state LO. Release is synchronous to clk50m by the board.
- Synchroniser: SYNC_STAGES-deep shift chain per channel. The last stage is s[i].
- Per-channel FSM states are LO, LO2HI, HI and HI2LO. Each channel has a debounce counter dcnt and a long counter lcnt.
  - LO: if s=1, go to LO2HI and set dcnt=0.
  - LO2HI:
    - s=0: go to LO with no pulse (bounce rejected).
    - s=1 and dcnt==DBNC_CYC-1: go to HI, sw_dbnc<=1, sw_hi<=1 for one cycle, lcnt<=0.
    - otherwise dcnt++.
  - HI: if s=0, go to HI2LO and set dcnt=0. Otherwise, when LONG_CYC!=0, lcnt advances (see long-press rules).
  - HI2LO:
    - s=1: go back to HI with no pulse; lcnt keeps its value (frozen while in HI2LO).
    - s=0 and dcnt==DBNC_CYC-1: go to LO, sw_dbnc<=0, sw_lo<=1 for one cycle.
    - otherwise dcnt++.
- Latency: the sw edge is sampled at posedge 1. sw_dbnc changes and the edge pulse asserts after posedge SYNC_STAGES+DBNC_CYC+1, provided sw is stable throughout. Pulses are registered and aligned with the sw_dbnc change.
- Long-press, only in HI with LONG_CYC!=0:
  - lcnt++ each HI cycle.
  - When lcnt reaches LONG_CYC-1, sw_long pulses one cycle.
  - If REPEAT_EN=0, no further pulses until the channel leaves HI.
  - If REPEAT_EN=1, lcnt reloads to LONG_CYC-REPEAT_CYC, giving a pulse every REPEAT_CYC cycles while in HI.
  - Leaving via HI2LO->LO clears lcnt.
- Counters saturate, never wrap. dcnt must not exceed DBNC_CYC-1.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- sw_hi, sw_lo and sw_long on one channel are mutually exclusive in any cycle. sw_long never coincides with sw_hi.
- Input high during/at reset release: the channel starts in LO, then debounces normally, producing sw_hi after the full latency.
- Reset mid-operation: in-flight pulses are dropped, and no sw_lo is generated for channels that were high.
- sw_dbnc only ever changes in the LO2HI->HI and HI2LO->LO transitions.

Test Plan:
- Clean press, params N_CH=2, SYNC_STAGES=2, DBNC_CYC=4, LONG_CYC=0: hold sw[0]=1 from negedge before posedge 1 -> sw_dbnc[0]=1 and sw_hi[0]=1 for exactly one cycle after posedge 7; sw[1] outputs stay 0.
- Bounce: sw[0] toggles 1 for 3 cycles, 0 for 1, 1 for 2, 0 for 5 (DBNC_CYC=4) -> sw_dbnc, sw_hi and sw_lo remain 0 throughout.
- Release:
  - After a debounced high, a 2-cycle low glitch -> no sw_lo.
  - A stable low -> sw_lo pulses once, 7 cycles after the first low sample.
  - sw_dbnc falls in the same cycle as the sw_lo pulse.
- Long press, LONG_CYC=10, REPEAT_EN=0: hold high 40 cycles -> exactly one sw_long, 10 cycles after sw_hi.
  - With REPEAT_EN=1 and REPEAT_CYC=5: pulses at +10, +15, +20, ... until release.
- Multi-channel plus reset: press ch0 and ch1 in the same cycle -> identical simultaneous sw_hi. Assert rst_n=0 mid-hold -> all outputs 0 immediately (async), with no sw_lo. After release with inputs still high -> sw_hi again after 7 cycles.
